// File: rtl/network_mul_share_arb.sv
// network_mul_share_arb: round-robin sharing of one 15s x 16s pipelined multiplier among N_REQ requesters
module network_mul_share_arb #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 2
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [15*N_REQ-1:0] req_a,
    input  logic [16*N_REQ-1:0] req_b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [29:0]         res_data,
    output logic [ID_W-1:0]     res_id,
    output logic                mul_ce,
    output logic [14:0]         mul_din0,
    output logic [15:0]         mul_din1,
    input  logic [29:0]         mul_dout,
    output logic [31:0]         op_count
);
    logic [ID_W-1:0]              rr_ptr;
    logic [ID_W-1:0]              gnt;
    logic                         gnt_vld;
    logic                         hs;
    logic [MUL_LAT-1:0]           vld;
    logic [MUL_LAT-1:0][ID_W-1:0] id;

    // Result channel comes from the last tag stage; a waiting result freezes the whole pipeline
    always_comb begin
        res_valid = ap_rst_n & vld[MUL_LAT-1];
        res_id    = ap_rst_n ? id[MUL_LAT-1] : '0;
        res_data  = mul_dout;
        mul_ce    = ap_rst_n & (~res_valid | res_ready);
    end

    // Round-robin search upward from rr_ptr; descending loop leaves the nearest valid as winner
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
                gnt_vld = 1'b1;
                gnt     = ID_W'((int'(rr_ptr) + k) % N_REQ);
            end
        hs        = gnt_vld & mul_ce;
        req_ready = hs ? N_REQ'(1) << gnt : '0;
        mul_din0  = gnt_vld ? req_a[15*int'(gnt) +: 15] : '0;
        mul_din1  = gnt_vld ? req_b[16*int'(gnt) +: 16] : '0;
    end

    // Tag pipeline mirrors the multiplier stages; pointer and counter advance only on handshakes
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            vld      <= '0;
            id       <= '0;
            rr_ptr   <= '0;
            op_count <= '0;
        end else begin
            if (mul_ce) begin
                vld[0] <= hs;
                id[0]  <= gnt;
                for (int i = 1; i < MUL_LAT; i++) begin
                    vld[i] <= vld[i-1];
                    id[i]  <= id[i-1];
                end
            end
            if (hs)
                rr_ptr <= (int'(gnt) == N_REQ - 1) ? '0 : gnt + 1'b1;
            if (res_valid & res_ready)
                op_count <= op_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_network_mul_share_arb.sv
// tb_network_mul_share_arb: randomized and directed checks against a queue-based reference model
module tb_network_mul_share_arb;
    localparam int N = 4;
    localparam int L = 2;

    typedef struct {
        logic [29:0] p;
        int          id;
        int          age;
    } ent_t;

    logic            ap_clk = 1'b0;
    logic            ap_rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [15*N-1:0] req_a = '0;
    logic [16*N-1:0] req_b = '0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [29:0]     res_data;
    logic [1:0]      res_id;
    logic            mul_ce;
    logic [14:0]     mul_din0;
    logic [15:0]     mul_din1;
    logic [29:0]     mul_dout;
    logic [31:0]     op_count;
    logic [29:0]     m1, m2;

    int          tests = 0;
    int          fails = 0;
    ent_t        q[$];
    int          rr = 0;
    int          cnt = 0;
    logic [N-1:0] acc;
    logic [29:0] last_data;

    always #5 ap_clk = ~ap_clk;

    network_mul_share_arb #(.N_REQ(N), .ID_W(2), .MUL_LAT(L)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
        .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .op_count(op_count)
    );

    // Behavioural stand-in for the two-stage ce-gated multiplier
    always @(posedge ap_clk)
        if (mul_ce) begin
            m1 <= 30'(longint'($signed(mul_din0)) * longint'($signed(mul_din1)));
            m2 <= m1;
        end
    assign mul_dout = m2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic signed [14:0] a, input logic signed [15:0] b);
        req_valid[i]      = v;
        req_a[15*i +: 15] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic set_rand(input int i, input logic v);
        set_req(i, v, 15'($urandom), 16'($urandom));
    endtask

    // One clock: check DUT outputs against the model at negedge, then advance the model across the posedge
    task automatic cycle();
        int           g;
        logic         rv;
        logic         ce;
        logic [N-1:0] rdy;
        ent_t         e;
        @(negedge ap_clk);
        acc = '0;
        g = -1;
        for (int k = N - 1; k >= 0; k--)
            if (req_valid[(rr + k) % N]) g = (rr + k) % N;
        rv  = ap_rst_n && q.size() > 0 && q[0].age == L - 1;
        ce  = ap_rst_n && !(rv && !res_ready);
        rdy = (ce && g >= 0) ? N'(1) << g : '0;
        check("req_ready", 64'(req_ready), 64'(rdy));
        check("mul_ce", 64'(mul_ce), 64'(ce));
        check("res_valid", 64'(res_valid), 64'(rv));
        check("op_count", 64'(op_count), 64'(cnt));
        if (rv) begin
            check("res_data", 64'(res_data), 64'(q[0].p));
            check("res_id", 64'(res_id), 64'(q[0].id));
        end
        if (!ap_rst_n) check("res_id_rst", 64'(res_id), 64'd0);
        if (!ap_rst_n) begin
            q.delete();
            rr  = 0;
            cnt = 0;
        end else begin
            if (rv && res_ready) begin
                last_data = res_data;
                void'(q.pop_front());
                cnt++;
            end
            if (ce) begin
                foreach (q[i]) q[i].age = q[i].age + 1;
                if (g >= 0) begin
                    e.p   = 30'(longint'($signed(req_a[15*g +: 15])) * longint'($signed(req_b[16*g +: 16])));
                    e.id  = g;
                    e.age = 0;
                    q.push_back(e);
                    rr     = (g + 1) % N;
                    acc[g] = 1'b1;
                end
            end
        end
        @(posedge ap_clk);
        #1;
    endtask

    task automatic drain();
        req_valid = '0;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
    endtask

    initial begin
        logic signed [14:0] ca[3];
        logic signed [15:0] cb[3];
        logic [29:0]        cp[3];
        ca = '{-15'sd16384, 15'sd16383, 15'sd0};
        cb = '{-16'sd32768, 16'sd32767, -16'sd32768};
        cp = '{30'h2000_0000, 30'd536821761, 30'd0};

        // reset state
        cycle();
        cycle();
        ap_rst_n  = 1'b1;
        res_ready = 1'b1;

        // single op from requester 2
        set_req(2, 1'b1, 15'sd100, -16'sd7);
        cycle();
        check("single_accept", 64'(acc), 64'b0100);
        set_req(2, 1'b0, 15'sd0, 16'sd0);
        for (int i = 0; i < 3; i++) cycle();
        check("single_data", 64'(last_data), 64'(30'h3FFF_FD44));
        check("single_count", 64'(op_count), 64'd1);

        // corner operands
        for (int c = 0; c < 3; c++) begin
            set_req(0, 1'b1, ca[c], cb[c]);
            cycle();
            set_req(0, 1'b0, 15'sd0, 16'sd0);
            for (int i = 0; i < 3; i++) cycle();
            check("corner_data", 64'(last_data), 64'(cp[c]));
        end

        // all requesters valid: strict rotation, one product per cycle
        for (int i = 0; i < N; i++) set_rand(i, 1'b1);
        for (int n = 0; n < 8; n++) begin
            cycle();
            for (int i = 0; i < N; i++) if (acc[i]) set_rand(i, 1'b1);
        end
        drain();
        check("burst_count", 64'(op_count), 64'd12);

        // backpressure: consumer stalls for 5 cycles after the first result
        for (int i = 0; i < N; i++) set_rand(i, 1'b1);
        for (int n = 0; n < 2; n++) begin
            cycle();
            for (int i = 0; i < N; i++) if (acc[i]) set_rand(i, 1'b1);
        end
        res_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            cycle();
            check("stall_ce", 64'(mul_ce), 64'd0);
        end
        res_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            cycle();
            for (int i = 0; i < N; i++) if (acc[i]) set_rand(i, 1'b1);
        end
        drain();
        check("stall_count", 64'(op_count), 64'd20);

        // reset with two products in flight
        set_rand(1, 1'b1);
        set_rand(2, 1'b1);
        cycle();
        cycle();
        req_valid = '0;
        ap_rst_n  = 1'b0;
        cycle();
        ap_rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_rand(i, 1'b1);
        cycle();
        check("post_rst_grant", 64'(acc), 64'b0001);
        drain();
        check("post_rst_count", 64'(op_count), 64'd1);

        // sparse traffic from requester 3 with bubbles
        for (int n = 0; n < 12; n++) begin
            set_rand(3, (n % 2) == 0);
            cycle();
        end
        drain();
        check("sparse_count", 64'(op_count), 64'd7);

        // random traffic, random backpressure, occasional reset
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++)
                if (acc[i] || !req_valid[i] || $urandom_range(0, 9) == 0)
                    set_rand(i, $urandom_range(0, 2) != 0);
            res_ready = $urandom_range(0, 9) < 7;
            ap_rst_n  = $urandom_range(0, 299) != 0;
            cycle();
        end
        ap_rst_n = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
